// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and the future serial receiver:
// frame FSM state encoding, line levels and a counter-width helper.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // A counter over n values needs at least one bit even when n == 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_register.sv
// General-purpose register: clear, parallel load, increment, decrement and
// shift left/right with serial fill. Async active-low reset to zero.
module serial_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             cl,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             sl,
    input  logic             ir,
    input  logic             il,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Operations are mutually exclusive by priority: cl > ld > inc > dec > sr > sl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (cl) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (inc) begin
            r_q <= r_q + WIDTH'(1);
        end else if (dec) begin
            r_q <= r_q - WIDTH'(1);
        end else if (sr) begin
            r_q <= {ir, r_q[WIDTH-1:1]};
        end else if (sl) begin
            r_q <= {r_q[WIDTH-2:0], il};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: start bit, DATA_WIDTH bits LSB first, optional
// even parity (enabled by defining SERIAL_TX_PARITY_EN), stop bit. tx is a flop.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_baud;
    logic [BW-1:0]         r_bit;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  w_baud_end;
    logic                  w_ld;
    logic                  w_sr;
    logic [DATA_WIDTH-1:0] w_q;
    logic                  w_unused_q;
`ifdef SERIAL_TX_PARITY_EN
    logic                  r_par;
`endif

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_ld       = (r_state == IDLE) && in_valid;
    assign w_sr       = (r_state == DATA) && w_baud_end;
    assign w_unused_q = ^w_q;

    serial_register #(.WIDTH(DATA_WIDTH)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (w_ld),
        .cl    (1'b0),
        .inc   (1'b0),
        .dec   (1'b0),
        .sr    (w_sr),
        .sl    (1'b0),
        .ir    (1'b0),
        .il    (1'b0),
        .d     (in_data),
        .q     (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (in_valid)   w_state_next = START;
            START: if (w_baud_end) w_state_next = DATA;
            DATA: begin
                if (w_baud_end && (r_bit == BIT_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (w_baud_end) w_state_next = STOP;
`endif
            STOP:  if (w_baud_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE);
        busy     = (r_state != IDLE);
        done     = (r_state == STOP) && w_baud_end;
        tx       = r_tx;
    end

    // tx is registered from the level of the state being entered; a shift in
    // the same edge means the next data bit is the one above the current LSB.
    always_comb begin
        w_tx_next = IDLE_LEVEL;
        case (w_state_next)
            START:  w_tx_next = START_BIT;
            DATA:   w_tx_next = w_sr ? w_q[1] : w_q[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: w_tx_next = r_par;
`endif
            STOP:   w_tx_next = STOP_BIT;
            default: w_tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= IDLE_LEVEL;
            r_baud <= '0;
            r_bit  <= '0;
        end else begin
            r_tx <= w_tx_next;
            if ((r_state == IDLE) || w_baud_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end
            if (r_state != DATA) begin
                r_bit <= '0;
            end else if (w_baud_end) begin
                r_bit <= r_bit + BW'(1);
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_ld) begin
            r_par <= ^in_data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: expected line levels are queued per frame at
// handshake and popped bit by bit while the DUT transmits.
module tb_serial_tx;

    localparam int DW  = 16;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME  = (DW + 2 + PB) * CPB;
    localparam int FRAME1 = (DW + 2 + PB);

    logic          clk;
    logic          rst_n;
    logic          in_valid,  in_valid1;
    logic [DW-1:0] in_data,   in_data1;
    logic          in_ready,  in_ready1;
    logic          tx,        tx1;
    logic          busy,      busy1;
    logic          done,      done1;

    logic exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx(tx), .busy(busy), .done(done)
    );

    serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic push_frame(input logic [DW-1:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            miscompares++; $display("FAIL reset_init busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
        in_valid = 1'b1; in_data = 16'h5555;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got=%b want=1", tx); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
        vectors++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_dut1 tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame(input logic [DW-1:0] d, input bit hold, input logic [DW-1:0] nd);
        int   cyc, dn, done_cyc, rdy_hi, t;
        logic b;
        if (in_valid !== 1'b1) begin
            t = 0;
            while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL idle_timeout in_ready=%b want=1", in_ready);
            end
            in_valid = 1'b1; in_data = d;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL handshake_ready d=%h got=%b want=1", d, in_ready);
        end
        push_frame(d);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        cyc = 0; dn = 0; done_cyc = -1; rdy_hi = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            repeat (CPB) begin
                cyc++;
                vectors++;
                if (tx !== b) begin
                    miscompares++; $display("FAIL tx_level d=%h cyc=%0d got=%b want=%b", d, cyc, tx, b);
                end
                if (done === 1'b1) begin dn++; done_cyc = cyc; end
                if (in_ready !== 1'b0) rdy_hi++;
                @(negedge clk);
            end
        end
        vectors++;
        if (dn != 1 || done_cyc != FRAME) begin
            miscompares++; $display("FAIL done_pulse d=%h count=%0d cyc=%0d want count=1 cyc=%0d", d, dn, done_cyc, FRAME);
        end
        vectors++;
        if (rdy_hi != 0) begin
            miscompares++; $display("FAIL ready_during_frame d=%h high_cycles=%0d want=0", d, rdy_hi);
        end
        vectors++;
        if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_after d=%h tx=%b ready=%b busy=%b want 1 1 0", d, tx, in_ready, busy);
        end
        if (hold) in_data = nd;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 16'h0001;
        test_frame(16'h0001, 1'b1, 16'hFFFF);
        test_frame(16'hFFFF, 1'b0, 16'h0000);
    endtask

    task automatic test_mid_reset();
        int   dn;
        logic [DW-1:0] d;
        d = 16'h1234;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (33) @(negedge clk);
        vectors++;
        if (tx !== d[7]) begin miscompares++; $display("FAIL bit7_level got=%b want=%b", tx, d[7]); end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_reset tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
        dn = 0;
        repeat (3) begin @(negedge clk); if (done === 1'b1) dn++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (done === 1'b1) dn++; end
        vectors++;
        if (dn != 0) begin miscompares++; $display("FAIL abort_no_done pulses=%0d want=0", dn); end
        test_frame(16'h00FF, 1'b0, 16'h0000);
    endtask

    task automatic test_cpb1();
        int   cyc, dn, done_cyc, t;
        logic b;
        t = 0;
        while (in_ready1 !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        vectors++;
        if (in_ready1 !== 1'b1) begin miscompares++; $display("FAIL cpb1_ready got=%b want=1", in_ready1); end
        in_valid1 = 1'b1; in_data1 = 16'h8001;
        push_frame(16'h8001);
        @(negedge clk);
        in_valid1 = 1'b0;
        cyc = 0; dn = 0; done_cyc = -1;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            cyc++;
            vectors++;
            if (tx1 !== b) begin miscompares++; $display("FAIL cpb1_tx cyc=%0d got=%b want=%b", cyc, tx1, b); end
            if (done1 === 1'b1) begin dn++; done_cyc = cyc; end
            @(negedge clk);
        end
        vectors++;
        if (dn != 1 || done_cyc != FRAME1) begin
            miscompares++; $display("FAIL cpb1_done count=%0d cyc=%0d want count=1 cyc=%0d", dn, done_cyc, FRAME1);
        end
        vectors++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++; $display("FAIL cpb1_idle tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
        end
    endtask

    task automatic test_parity();
        test_frame(16'h0007, 1'b0, 16'h0000);
        test_frame(16'h0003, 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_frame(16'hA5C3, 1'b0, 16'h0000);
        test_back_to_back();
        test_mid_reset();
        test_cpb1();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
